// File: rtl/mebx_button_poller.sv
// rtl/mebx_button_poller.sv - Avalon-MM poller for a 4-bit button PIO
// Periodically reads the PIO data register, debounces it, and reports edges and a maskable irq.
module mebx_button_poller #(
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int TIMEOUT      = 255,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [3:0]  btn_state,
  output logic [3:0]  btn_press,
  output logic [3:0]  btn_release,
  input  logic [3:0]  evt_clr,
  input  logic [3:0]  irq_mask,
  output logic        irq,
  output logic        bus_err,
  output logic        poll_overrun
);

  localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   poll_cnt;
  logic            tick;
  logic [7:0]      stall_cnt, stall_nxt;
  logic            timeout_hit;
  logic [3:0]      sample;
  logic [3:0]      differ;
  logic [3:0]      flip;
  logic [3:0][3:0] db_cnt;
  logic [3:0][3:0] cnt_inc;
  logic [3:0]      evt;
  logic            unused_readdata;

  assign unused_readdata = ^avm_readdata[31:4];

  // Free-running poll timer; it keeps counting even while a read is in flight.
  assign tick = (poll_cnt == TW'(POLL_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    stall_nxt   = stall_cnt;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = READ;
          stall_nxt = '0;
        end
      end
      READ: begin
        if (!avm_waitrequest) begin
          state_nxt = CAPTURE;
        end else if (stall_cnt == 8'(TIMEOUT - 1)) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end else begin
          stall_nxt = stall_cnt + 8'd1;
        end
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Driven from state alone so an asynchronous reset drops the request at once.
  assign avm_read    = (state == READ);
  assign avm_address = 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_err      <= 1'b0;
      poll_overrun <= 1'b0;
    end else begin
      bus_err      <= timeout_hit;
      poll_overrun <= tick && (state != IDLE);
    end
  end

  assign sample = ACTIVE_LOW ? ~avm_readdata[3:0] : avm_readdata[3:0];

  always_comb begin
    differ  = '0;
    flip    = '0;
    cnt_inc = '0;
    for (int i = 0; i < 4; i++) begin
      differ[i]  = (sample[i] != btn_state[i]);
      cnt_inc[i] = db_cnt[i] + 4'd1;
      flip[i]    = differ[i] && (cnt_inc[i] == 4'(DEBOUNCE_CNT));
    end
  end

  // A matching sample restarts the run; a flip also restarts it, so counters never pass DEBOUNCE_CNT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt      <= '0;
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      if (state == CAPTURE) begin
        for (int i = 0; i < 4; i++) begin
          if (!differ[i] || flip[i]) begin
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= cnt_inc[i];
          end
        end
        btn_state   <= btn_state ^ flip;
        btn_press   <= flip & sample;
        btn_release <= flip & ~sample;
      end
    end
  end

  // A press in the same cycle as its clear keeps the event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt <= '0;
      irq <= 1'b0;
    end else begin
      evt <= (evt & ~evt_clr) | btn_press;
      irq <= |(evt & irq_mask);
    end
  end

endmodule

// File: tb/tb_mebx_button_poller.sv
// tb/tb_mebx_button_poller.sv - randomized bench for mebx_button_poller with a behavioural model
module tb_mebx_button_poller;

  localparam int PD = 4;
  localparam int DB = 3;
  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic [3:0]  btn_state, btn_press, btn_release;
  logic [3:0]  evt_clr = 4'h0;
  logic [3:0]  irq_mask = 4'h0;
  logic        irq, bus_err, poll_overrun;

  mebx_button_poller #(
    .POLL_DIV(PD), .DEBOUNCE_CNT(DB), .TIMEOUT(TO), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
    .evt_clr(evt_clr), .irq_mask(irq_mask), .irq(irq),
    .bus_err(bus_err), .poll_overrun(poll_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: poll schedule, read duration and per-bit run lengths.
  int         m_timer = 0;
  int         m_stall = 0;
  int         m_run[4] = '{0, 0, 0, 0};
  bit         m_reading = 1'b0;
  bit         m_capture = 1'b0;
  logic [3:0] m_state = 4'h0, m_press = 4'h0, m_release = 4'h0, m_evt = 4'h0;
  logic       m_irq = 1'b0, m_bus_err = 1'b0, m_overrun = 1'b0;

  task automatic model_reset();
    m_timer = 0; m_stall = 0; m_reading = 1'b0; m_capture = 1'b0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_state = 4'h0; m_press = 4'h0; m_release = 4'h0; m_evt = 4'h0;
    m_irq = 1'b0; m_bus_err = 1'b0; m_overrun = 1'b0;
  endtask

  task automatic model_step();
    logic       tick, busy, n_irq, n_err;
    logic [3:0] s, n_state, n_press, n_release, n_evt;
    bit         n_reading, n_capture;
    tick      = (m_timer == PD - 1);
    busy      = m_reading || m_capture;
    n_irq     = |(m_evt & irq_mask);
    n_evt     = (m_evt & ~evt_clr) | m_press;
    n_state   = m_state;
    n_press   = 4'h0;
    n_release = 4'h0;
    if (m_capture) begin
      s = ~avm_readdata[3:0];
      for (int i = 0; i < 4; i++) begin
        if (s[i] == m_state[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            m_run[i]   = 0;
            n_state[i] = s[i];
            if (s[i]) n_press[i] = 1'b1;
            else      n_release[i] = 1'b1;
          end
        end
      end
    end
    n_err     = 1'b0;
    n_reading = m_reading;
    n_capture = 1'b0;
    if (m_reading) begin
      if (!avm_waitrequest) begin
        n_reading = 1'b0;
        n_capture = 1'b1;
      end else if (m_stall + 1 == TO) begin
        n_reading = 1'b0;
        n_err     = 1'b1;
      end else begin
        m_stall = m_stall + 1;
      end
    end else if (!m_capture && tick) begin
      n_reading = 1'b1;
      m_stall   = 0;
    end
    m_overrun = tick && busy;
    m_timer   = (m_timer + 1) % PD;
    m_reading = n_reading;
    m_capture = n_capture;
    m_state   = n_state;
    m_press   = n_press;
    m_release = n_release;
    m_evt     = n_evt;
    m_irq     = n_irq;
    m_bus_err = n_err;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_step();
  end

  // Stimulus and checking state (all owned by the main process).
  logic [3:0] in_port = 4'hF;
  int  wmode = 0;
  int  burst = 0;
  int  rd_age = 0;
  bit  acc_prev = 1'b0;
  bit  rnd_en = 1'b0;
  bit  cmp_en = 1'b0;
  int  press0 = 0, press1 = 0, release0 = 0, err_cnt = 0, ovr_cnt = 0;
  int  read_hi = 0, run_len = 0, max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    chk("avm_read", 32'(avm_read), 32'(m_reading));
    chk("avm_address", 32'(avm_address), 32'd0);
    chk("btn_state", 32'(btn_state), 32'(m_state));
    chk("btn_press", 32'(btn_press), 32'(m_press));
    chk("btn_release", 32'(btn_release), 32'(m_release));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("bus_err", 32'(bus_err), 32'(m_bus_err));
    chk("poll_overrun", 32'(poll_overrun), 32'(m_overrun));
    if (btn_press[0]) press0++;
    if (btn_press[1]) press1++;
    if (btn_release[0]) release0++;
    if (bus_err) err_cnt++;
    if (poll_overrun) ovr_cnt++;
    if (avm_read) begin
      read_hi++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  endtask

  task automatic drive();
    logic        w;
    logic [31:0] r;
    rd_age = avm_read ? rd_age + 1 : 0;
    w = 1'b0;
    case (wmode)
      1: begin
        if (burst > 0) begin
          w = 1'b1;
          burst--;
        end else if ($urandom_range(0, 40) == 0) begin
          w = 1'b1;
          burst = $urandom_range(3, 9);
        end else begin
          w = ($urandom_range(0, 3) == 0);
        end
      end
      2: w = 1'b1;
      3: w = avm_read && (rd_age <= 3);
      default: w = 1'b0;
    endcase
    avm_waitrequest = w;
    if (rnd_en) begin
      if ($urandom_range(0, 5) == 0) in_port = 4'($urandom_range(0, 15));
      evt_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 49) == 0) irq_mask = 4'($urandom_range(0, 15));
    end
    r = $urandom();
    avm_readdata = acc_prev ? {r[31:4], in_port} : r;
    acc_prev = avm_read && !w;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (cmp_en) compare();
      drive();
    end
  endtask

  int  snap;
  bit  found;

  initial begin
    cycles(3);
    chk("rst_btn_state", 32'(btn_state), 32'h0);
    chk("rst_avm_read", 32'(avm_read), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_press", 32'(btn_press), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_overrun", 32'(poll_overrun), 32'h0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Idle buttons, zero-wait slave: one single-cycle read every PD cycles.
    snap = read_hi;
    cycles(20);
    chk("read_count_20cyc", 32'(read_hi - snap), 32'd5);
    chk("idle_state", 32'(btn_state), 32'h0);

    // Press bit0 (active-low raw 0).
    in_port = 4'hE;
    cycles(20);
    chk("press_state", 32'(btn_state), 32'h1);
    chk("press_model", 32'(m_state), 32'h1);
    chk("press0_pulses", 32'(press0), 32'd1);

    // Bit1 glitch for exactly two polls.
    in_port = 4'hC;
    cycles(8);
    in_port = 4'hE;
    cycles(20);
    chk("glitch_state", 32'(btn_state), 32'h1);
    chk("glitch_press1", 32'(press1), 32'd0);

    // Release bit0.
    in_port = 4'hF;
    cycles(20);
    chk("release_state", 32'(btn_state), 32'h0);
    chk("release0_pulses", 32'(release0), 32'd1);

    // Interrupt path.
    irq_mask = 4'h1;
    cycles(2);
    chk("irq_set", 32'(irq), 32'h1);
    evt_clr = 4'h1;
    cycles(1);
    evt_clr = 4'h0;
    chk("irq_after_1", 32'(irq), 32'h1);
    cycles(1);
    chk("irq_after_2", 32'(irq), 32'h0);

    // Clear in the same cycle as a new press: the press wins.
    in_port = 4'hE;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycles(1);
      if (btn_press[0]) found = 1'b1;
    end
    chk("press_seen", 32'(found), 32'h1);
    evt_clr = 4'h1;
    cycles(1);
    evt_clr = 4'h0;
    cycles(2);
    chk("irq_clr_vs_set", 32'(irq), 32'h1);

    // Slave stalls forever: read held TO cycles, bus_err, state kept.
    wmode = 2;
    snap = err_cnt;
    max_run = 0;
    cycles(24);
    chk("timeout_err", 32'(err_cnt - snap > 0), 32'h1);
    chk("timeout_read_len", 32'(max_run), 32'(TO));
    chk("timeout_state", 32'(btn_state), 32'h1);

    // Three stall cycles per read overrun a PD=4 poll period.
    wmode = 3;
    snap = ovr_cnt;
    cycles(24);
    chk("overrun_seen", 32'(ovr_cnt - snap > 0), 32'h1);

    // Random traffic.
    wmode  = 1;
    rnd_en = 1'b1;
    cycles(3000);
    rnd_en  = 1'b0;
    wmode   = 0;
    evt_clr = 4'h0;

    // Reset while a read is outstanding.
    irq_mask = 4'hF;
    in_port  = 4'hF;
    cycles(20);
    in_port = 4'hE;
    cycles(20);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycles(1);
      if (avm_read) found = 1'b1;
    end
    chk("read_seen", 32'(found), 32'h1);
    chk("pre_reset_state", 32'(btn_state), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_avm_read", 32'(avm_read), 32'h0);
    chk("async_btn_state", 32'(btn_state), 32'h0);
    chk("async_irq", 32'(irq), 32'h0);
    cycles(3);
    reset_n = 1'b1;
    snap = press0;
    cycles(20);
    chk("resume_state", 32'(btn_state), 32'h1);
    chk("resume_press0", 32'(press0 - snap), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
